scan_arbiter: RTL and testbench

SCAN_ARBITER -- requirements
Module: scan_arbiter

---
 rtl/scan_arbiter.sv | 176 +++++++++++++++++
 tb/tb_scan_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_arbiter.sv
// Two-scanner readout arbiter: ping-pong scan sequencing plus a granted byte-by-byte buffer transfer.
// Define SCAN_ARB_ROUND_ROBIN_EN to alternate grants on ties; otherwise scanner 0 always wins.
module scan_arbiter #(
    parameter int unsigned BUF_DEPTH = 10,
    parameter int unsigned RD_GAP    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_go,
    input  logic       xfer_req,
    input  logic       rd_strobe,
    input  logic [1:0] s_ready,
    input  logic [1:0] s_start2,
    input  logic [7:0] s0_data,
    input  logic [7:0] s1_data,
    output logic [1:0] s_start_scan,
    output logic [1:0] s_transfer,
    output logic [1:0] s_read_inc,
    output logic [7:0] data_out,
    output logic       owner,
    output logic       busy,
    output logic       xfer_done,
    output logic [3:0] byte_cnt
);

    localparam int unsigned     GapW     = (RD_GAP > 2) ? $clog2(RD_GAP) : 1;
    localparam logic [3:0]      DepthCnt = 4'(BUF_DEPTH);
    localparam logic [GapW-1:0] GapLoad  = GapW'(RD_GAP - 1);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StGrant   = 2'b01,
        StXfer    = 2'b10,
        StRelease = 2'b11
    } state_e;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic [1:0]      read_inc_q, read_inc_d;
    logic            take_grant;
    logic            grant_idx;
    logic            accept;

    logic [1:0]      start_q, start_d;
    logic            go_prev_q;
    logic            start2_prev_q;
    logic            unused_start2;

    assign unused_start2 = s_start2[1];

    assign take_grant = (state_q == StIdle) && xfer_req && (s_ready != 2'b00);

`ifdef SCAN_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    // On a tie the scanner not served last wins; last_q resets to 1 so scanner 0 goes first.
    assign grant_idx = (s_ready == 2'b11) ? ~last_q : ~s_ready[0];

    always_comb begin
        last_d = last_q;
        if (take_grant) begin
            last_d = grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign grant_idx = ~s_ready[0];
`endif

    // Strobes are honoured only in XFER, with the request still up, outside the gap window.
    assign accept = (state_q == StXfer) && xfer_req && rd_strobe &&
                    (gap_q == '0) && (cnt_q < DepthCnt);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        read_inc_d = 2'b00;
        gap_d      = (gap_q != '0) ? gap_q - GapW'(1) : gap_q;

        unique case (state_q)
            StIdle: begin
                if (take_grant) begin
                    state_d = StGrant;
                    owner_d = grant_idx;
                end
            end
            StGrant: begin
                state_d = StXfer;
            end
            StXfer: begin
                if (accept) begin
                    cnt_d      = cnt_q + 4'd1;
                    read_inc_d = owner_q ? 2'b10 : 2'b01;
                    gap_d      = GapLoad;
                end
                if ((cnt_q >= DepthCnt) || !xfer_req) begin
                    state_d = StRelease;
                end
            end
            StRelease: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            cnt_q      <= 4'd0;
            gap_q      <= '0;
            read_inc_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            read_inc_q <= read_inc_d;
        end
    end

    // Scan sequencer: start scanner 0 on a scan_go rise, hand over to scanner 1 on its start2 rise.
    always_comb begin
        start_d = start_q;
        if (!scan_go) begin
            start_d = 2'b00;
        end else if (!go_prev_q) begin
            start_d = 2'b01;
        end else if (start_q[0] && s_start2[0] && !start2_prev_q) begin
            start_d = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            start_q       <= 2'b00;
            go_prev_q     <= 1'b0;
            start2_prev_q <= 1'b0;
        end else begin
            start_q       <= start_d;
            go_prev_q     <= scan_go;
            start2_prev_q <= s_start2[0];
        end
    end

    always_comb begin
        s_transfer = 2'b00;
        if ((state_q == StGrant) || (state_q == StXfer)) begin
            s_transfer = owner_q ? 2'b10 : 2'b01;
        end
    end

    // A short count in RELEASE means the host aborted, so no completion pulse.
    assign xfer_done    = (state_q == StRelease) && (cnt_q == DepthCnt);
    assign busy         = (state_q != StIdle);
    assign s_read_inc   = read_inc_q;
    assign byte_cnt     = cnt_q;
    assign owner        = owner_q;
    assign data_out     = owner_q ? s1_data : s0_data;
    assign s_start_scan = start_q;

endmodule

// File: tb/tb_scan_arbiter.sv
// Scoreboard bench for scan_arbiter: stimulus queues expected output events, a negedge monitor
// detects events on the DUT outputs and compares them in order.
module tb_scan_arbiter;

    localparam int unsigned BufDepth = 10;
    localparam int unsigned RdGap    = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       scan_go;
    logic       xfer_req;
    logic       rd_strobe;
    logic [1:0] s_ready;
    logic [1:0] s_start2;
    logic [7:0] s0_data;
    logic [7:0] s1_data;
    logic [1:0] s_start_scan;
    logic [1:0] s_transfer;
    logic [1:0] s_read_inc;
    logic [7:0] data_out;
    logic       owner;
    logic       busy;
    logic       xfer_done;
    logic [3:0] byte_cnt;

    scan_arbiter #(
        .BUF_DEPTH(BufDepth),
        .RD_GAP   (RdGap)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .scan_go     (scan_go),
        .xfer_req    (xfer_req),
        .rd_strobe   (rd_strobe),
        .s_ready     (s_ready),
        .s_start2    (s_start2),
        .s0_data     (s0_data),
        .s1_data     (s1_data),
        .s_start_scan(s_start_scan),
        .s_transfer  (s_transfer),
        .s_read_inc  (s_read_inc),
        .data_out    (data_out),
        .owner       (owner),
        .busy        (busy),
        .xfer_done   (xfer_done),
        .byte_cnt    (byte_cnt)
    );

    always #5 clk = ~clk;

    typedef enum logic [2:0] {EvGrant, EvRead, EvDone, EvRel, EvScan} ev_kind_e;
    typedef struct packed {
        ev_kind_e    kind;
        logic [11:0] val;
    } ev_t;

    ev_t        exp_q[$];
    int         n_cmp     = 0;
    int         n_bad     = 0;
    logic       mon_en    = 1'b0;
    logic [1:0] prev_xfer = 2'b00;
    logic [1:0] prev_scan = 2'b00;

    task automatic expect_ev(input ev_kind_e k, input logic [11:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_e k, input logic [11:0] v);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected %s event at %0t: actual val=%h, required no event",
                     k.name(), $time, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== k || e.val !== v) begin
                n_bad++;
                $display("FAIL event at %0t: actual %s val=%h, required %s val=%h",
                         $time, k.name(), v, e.kind.name(), e.val);
            end
        end
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %h, required %h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_reads(input int n, input int first, input logic [1:0] inc);
        for (int i = 0; i < n; i++) begin
            expect_ev(EvRead, {6'd0, inc, 4'(first + i)});
        end
    endtask

    // One strobe cycle followed by two idle cycles: spacing of 3.
    task automatic drive_strobes(input int n);
        for (int i = 0; i < n; i++) begin
            rd_strobe = 1'b1;
            tick(1);
            rd_strobe = 1'b0;
            tick(2);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (s_transfer != 2'b00 && prev_xfer == 2'b00)
                observe(EvGrant, {owner, s_transfer, busy, data_out});
            if (s_read_inc != 2'b00)
                observe(EvRead, {6'd0, s_read_inc, byte_cnt});
            if (xfer_done)
                observe(EvDone, {6'd0, byte_cnt, s_transfer});
            if (s_transfer == 2'b00 && prev_xfer != 2'b00)
                observe(EvRel, {7'd0, xfer_done, byte_cnt});
            if (s_start_scan != prev_scan)
                observe(EvScan, {10'd0, s_start_scan});
        end
        prev_xfer = s_transfer;
        prev_scan = s_start_scan;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ev_t e;
        rst       = 1'b0;
        scan_go   = 1'b0;
        xfer_req  = 1'b0;
        rd_strobe = 1'b0;
        s_ready   = 2'b00;
        s_start2  = 2'b00;
        s0_data   = 8'hA5;
        s1_data   = 8'h3C;
        tick(3);

        check("reset s_transfer", {10'd0, s_transfer}, 12'd0);
        check("reset s_read_inc", {10'd0, s_read_inc}, 12'd0);
        check("reset s_start_scan", {10'd0, s_start_scan}, 12'd0);
        check("reset busy", {11'd0, busy}, 12'd0);
        check("reset xfer_done", {11'd0, xfer_done}, 12'd0);
        check("reset byte_cnt", {8'd0, byte_cnt}, 12'd0);
        check("reset owner", {11'd0, owner}, 12'd0);
        mon_en = 1'b1;
        rst    = 1'b1;

        // Full transfer from scanner 0; s_ready falls mid-transfer and must not matter.
        expect_ev(EvGrant, {1'b0, 2'b01, 1'b1, 8'hA5});
        push_reads(10, 1, 2'b01);
        expect_ev(EvDone, {6'd0, 4'd10, 2'b00});
        expect_ev(EvRel, {7'd0, 1'b1, 4'd10});
        s_ready  = 2'b01;
        xfer_req = 1'b1;
        tick(2);
        s_ready = 2'b00;
        drive_strobes(10);
        xfer_req = 1'b0;
        tick(3);

        // Back-to-back strobes: second one ignored; then host abort without xfer_done.
        expect_ev(EvGrant, {1'b0, 2'b01, 1'b1, 8'hA5});
        expect_ev(EvRead, {6'd0, 2'b01, 4'd1});
        expect_ev(EvRead, {6'd0, 2'b01, 4'd2});
        expect_ev(EvRel, {7'd0, 1'b0, 4'd2});
        s_ready  = 2'b01;
        xfer_req = 1'b1;
        tick(2);
        rd_strobe = 1'b1;
        tick(2);
        rd_strobe = 1'b0;
        tick(2);
        rd_strobe = 1'b1;
        tick(1);
        rd_strobe = 1'b0;
        tick(2);
        xfer_req = 1'b0;
        tick(4);

        // Fresh reset so the tie-break history starts clean.
        rst = 1'b0;
        tick(2);
        rst = 1'b1;

        // Two tied requests, then scanner 1 alone.
        expect_ev(EvGrant, {1'b0, 2'b01, 1'b1, 8'hA5});
        expect_ev(EvRel, {7'd0, 1'b0, 4'd0});
`ifdef SCAN_ARB_ROUND_ROBIN_EN
        expect_ev(EvGrant, {1'b1, 2'b10, 1'b1, 8'h3C});
`else
        expect_ev(EvGrant, {1'b0, 2'b01, 1'b1, 8'hA5});
`endif
        expect_ev(EvRel, {7'd0, 1'b0, 4'd0});
        expect_ev(EvGrant, {1'b1, 2'b10, 1'b1, 8'h3C});
        expect_ev(EvRel, {7'd0, 1'b0, 4'd0});
        for (int t = 0; t < 3; t++) begin
            s_ready  = (t < 2) ? 2'b11 : 2'b10;
            xfer_req = 1'b1;
            tick(2);
            xfer_req = 1'b0;
            tick(3);
        end

        // Reset after four bytes: transfer dropped, count cleared, no completion.
        expect_ev(EvGrant, {1'b0, 2'b01, 1'b1, 8'hA5});
        push_reads(4, 1, 2'b01);
        expect_ev(EvRel, {7'd0, 1'b0, 4'd0});
        s_ready  = 2'b01;
        xfer_req = 1'b1;
        tick(2);
        drive_strobes(4);
        rst = 1'b0;
        tick(1);
        check("mid-reset byte_cnt", {8'd0, byte_cnt}, 12'd0);
        check("mid-reset busy", {11'd0, busy}, 12'd0);
        check("mid-reset xfer_done", {11'd0, xfer_done}, 12'd0);
        check("mid-reset s_read_inc", {10'd0, s_read_inc}, 12'd0);
        xfer_req = 1'b0;
        s_ready  = 2'b00;
        tick(1);
        rst = 1'b1;
        tick(2);

        // Ping-pong scan start sequence.
        expect_ev(EvScan, 12'h001);
        expect_ev(EvScan, 12'h002);
        expect_ev(EvScan, 12'h000);
        scan_go = 1'b1;
        tick(2);
        s_start2 = 2'b01;
        tick(2);
        scan_go = 1'b0;
        tick(1);
        s_start2 = 2'b00;
        tick(5);

        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing event: actual none, required %s val=%h", e.kind.name(), e.val);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
